// File: rtl/sparse_stream_encoder_pkg.sv
// sparse_stream_encoder_pkg
//   Shared definitions for the sparse stream encoder and the PE it feeds:
//   fp32 field positions, the zero test and the default mask width. Both
//   ends of the index/data protocol import these, so they agree on what
//   counts as a zero element and on how wide a mask is.
package sparse_stream_encoder_pkg;

  localparam int FP32_WIDTH          = 32;
  localparam int FP32_SIGN_BIT       = 31;
  localparam int FP32_MAG_MSB        = FP32_SIGN_BIT - 1;  // magnitude is [30:0]
  localparam int DEFAULT_VEC_LEN     = 32;                 // equals PE Mask_Width
  localparam int DEFAULT_INDEX_WIDTH = $clog2(DEFAULT_VEC_LEN);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } enc_state_t;

  // The sign bit is ignored, so -0.0 is zero; denormals have a nonzero
  // mantissa and therefore count as nonzero.
  function automatic logic is_zero_fp32(input logic [FP32_WIDTH-1:0] i_word);
    return (i_word[FP32_MAG_MSB:0] == '0);
  endfunction

endpackage

// File: rtl/sparse_stream_encoder_fifo.sv
// sparse_enc_fifo
//   Small synchronous FIFO holding encoded (index, data, last) entries.
//   Push and pop may happen in the same cycle at any fill level; a push
//   into a full FIFO is only taken when a pop frees a slot that cycle.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_push        write i_push_data this cycle
//   i_pop         remove the head entry this cycle (ignored when empty)
//   o_head        head entry (combinational read of the storage)
//   o_count       number of stored entries, 0..Depth
//   o_full        count == Depth
//   o_empty       count == 0
module sparse_enc_fifo #(
  parameter int Width = 36,
  parameter int Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [Width-1:0]           o_head,
  output logic [$clog2(Depth):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int Ptr_Width   = $clog2(Depth);
  localparam int Count_Width = Ptr_Width + 1;

  logic [Width-1:0]       r_mem [Depth];
  logic [Ptr_Width-1:0]   r_wr_ptr;
  logic [Ptr_Width-1:0]   r_rd_ptr;
  logic [Count_Width-1:0] r_count;
  logic                   w_pop_en;
  logic                   w_push_en;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == Count_Width'(Depth));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_pop_en  = i_pop && !o_empty;
  assign w_push_en = i_push && (!o_full || w_pop_en);

  // Storage has no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + Ptr_Width'(1);
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + Ptr_Width'(1);
      r_count <= r_count + Count_Width'(w_push_en) - Count_Width'(w_pop_en);
    end
  end

endmodule

// File: rtl/sparse_stream_encoder.sv
// sparse_stream_encoder
//   Producer end of the sparse PE index/data protocol. Dense fp32 words
//   arrive one per cycle; only nonzero elements leave, as (index, data)
//   pairs, with out_last on the final nonzero of each vector. A per-vector
//   nonzero bitmap is pulsed on mask_valid/mask_out for the PE mask load.
//   The most recent nonzero is parked in a hold register so it can be
//   tagged last once the vector end is seen.
// Optional feature: define SPARSE_ENC_NNZ_COUNT_EN to add output nnz_count
//   (nonzero count of the vector, valid with mask_valid).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        dense input handshake
//   in_data, in_last         dense element and end-of-vector flag
//   out_valid/out_ready      sparse output handshake
//   out_index, out_data      element position and value
//   out_last                 last nonzero entry of its vector
//   mask_valid, mask_out     one-cycle bitmap pulse and held bitmap
module sparse_stream_encoder
  import sparse_stream_encoder_pkg::*;
#(
  parameter int Data_Width  = FP32_WIDTH,
  parameter int Vec_Len     = DEFAULT_VEC_LEN,
  parameter int Index_Width = $clog2(Vec_Len),
  parameter int Fifo_Depth  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Data_Width-1:0]  in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [Index_Width-1:0] out_index,
  output logic [Data_Width-1:0]  out_data,
  output logic                   out_last,
  output logic                   mask_valid,
`ifdef SPARSE_ENC_NNZ_COUNT_EN
  output logic [Index_Width:0]   nnz_count,
`endif
  output logic [Vec_Len-1:0]     mask_out
);

  localparam int Entry_Width = Index_Width + Data_Width + 1;
  localparam int Count_Width = $clog2(Fifo_Depth) + 1;

  enc_state_t             r_state;
  enc_state_t             w_state_next;
  logic [Index_Width-1:0] r_cnt;
  logic                   r_hold_valid;
  logic [Index_Width-1:0] r_hold_index;
  logic [Data_Width-1:0]  r_hold_data;
  logic [Vec_Len-1:0]     r_mask_acc;
  logic [Vec_Len-1:0]     r_mask_out;
  logic                   r_mask_valid;

  logic                   w_accept;
  logic                   w_nonzero;
  logic                   w_end;
  logic [Vec_Len-1:0]     w_mask_bit;
  logic                   w_push;
  logic [Entry_Width-1:0] w_push_entry;
  logic                   w_hold_load;
  logic                   w_hold_clear;
  logic [Entry_Width-1:0] w_head;
  logic [Count_Width-1:0] w_count;
  logic                   w_full;
  logic                   w_empty;

  assign in_ready   = (r_state == ST_RUN) && !rst && (w_count < Count_Width'(Fifo_Depth));
  assign w_accept   = in_valid && in_ready;
  assign w_nonzero  = !is_zero_fp32(in_data);
  // Reaching the last slot ends the vector exactly as in_last would.
  assign w_end      = in_last || (r_cnt == Index_Width'(Vec_Len - 1));
  assign w_mask_bit = w_nonzero ? ({{(Vec_Len-1){1'b0}}, 1'b1} << r_cnt) : '0;

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_push_entry = '0;
    w_hold_load  = 1'b0;
    w_hold_clear = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_accept) begin
          if (w_nonzero) begin
            if (r_hold_valid) begin
              // Older nonzero is now known not to be last.
              w_push       = 1'b1;
              w_push_entry = {r_hold_index, r_hold_data, 1'b0};
              w_hold_load  = 1'b1;
              if (w_end) w_state_next = ST_FLUSH;
            end else if (w_end) begin
              w_push       = 1'b1;
              w_push_entry = {r_cnt, in_data, 1'b1};
            end else begin
              w_hold_load  = 1'b1;
            end
          end else if (w_end && r_hold_valid) begin
            w_push       = 1'b1;
            w_push_entry = {r_hold_index, r_hold_data, 1'b1};
            w_hold_clear = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (!w_full) begin
          w_push       = 1'b1;
          w_push_entry = {r_hold_index, r_hold_data, 1'b1};
          w_hold_clear = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_cnt        <= '0;
      r_hold_valid <= 1'b0;
      r_hold_index <= '0;
      r_hold_data  <= '0;
      r_mask_acc   <= '0;
      r_mask_out   <= '0;
      r_mask_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_mask_valid <= 1'b0;
      if (w_hold_load) begin
        r_hold_valid <= 1'b1;
        r_hold_index <= r_cnt;
        r_hold_data  <= in_data;
      end else if (w_hold_clear) begin
        r_hold_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_end) begin
          r_cnt        <= '0;
          r_mask_out   <= r_mask_acc | w_mask_bit;
          r_mask_acc   <= '0;
          r_mask_valid <= 1'b1;
        end else begin
          r_cnt        <= r_cnt + Index_Width'(1);
          r_mask_acc   <= r_mask_acc | w_mask_bit;
        end
      end
    end
  end

`ifdef SPARSE_ENC_NNZ_COUNT_EN
  logic [Index_Width:0] r_nnz_acc;
  logic [Index_Width:0] r_nnz_count;
  logic [Index_Width:0] w_nnz_sum;

  assign w_nnz_sum = r_nnz_acc + {{Index_Width{1'b0}}, w_nonzero};
  assign nnz_count = r_nnz_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nnz_acc   <= '0;
      r_nnz_count <= '0;
    end else if (w_accept) begin
      if (w_end) begin
        r_nnz_count <= w_nnz_sum;
        r_nnz_acc   <= '0;
      end else begin
        r_nnz_acc   <= w_nnz_sum;
      end
    end
  end
`endif

  sparse_enc_fifo #(
    .Width (Entry_Width),
    .Depth (Fifo_Depth)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (out_ready),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Outputs read as zero whenever nothing is queued.
  assign out_valid  = !w_empty;
  assign {out_index, out_data, out_last} = out_valid ? w_head : '0;
  assign mask_valid = r_mask_valid;
  assign mask_out   = r_mask_out;

endmodule

// File: tb/tb_sparse_stream_encoder.sv
module tb_sparse_stream_encoder;

  localparam int VL = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [31:0]   out_data;
  logic          out_last;
  logic          mask_valid;
  logic [VL-1:0] mask_out;
`ifdef SPARSE_ENC_NNZ_COUNT_EN
  logic [IW:0]   nnz_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] got_s[$];
  logic [63:0] exp_s[$];
  logic [63:0] got_m[$];
  logic [63:0] exp_m[$];

  always #5 clk = ~clk;

  sparse_stream_encoder #(
    .Data_Width (32),
    .Vec_Len    (VL),
    .Fifo_Depth (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_data   (out_data),
    .out_last   (out_last),
    .mask_valid (mask_valid),
`ifdef SPARSE_ENC_NNZ_COUNT_EN
    .nnz_count  (nnz_count),
`endif
    .mask_out   (mask_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ent(input int idx, input logic [31:0] d, input bit l);
    logic [IW-1:0] i3;
    i3 = idx[IW-1:0];
    return {28'b0, i3, d, l};
  endfunction

  function automatic logic [63:0] mk(input logic [VL-1:0] m, input int nnz);
    logic [3:0] n4;
`ifdef SPARSE_ENC_NNZ_COUNT_EN
    n4 = nnz[3:0];
`else
    n4 = 4'd0;
    if (nnz < 0) n4 = 4'd1;
`endif
    return {52'b0, n4, m};
  endfunction

  // Observe pops and mask pulses on the falling edge, away from updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        got_s.push_back({28'b0, out_index, out_data, out_last});
        $display("[TB] pop index=%0d data=%08h last=%0b", out_index, out_data, out_last);
      end
      if (mask_valid) begin
`ifdef SPARSE_ENC_NNZ_COUNT_EN
        got_m.push_back({52'b0, nnz_count[3:0], mask_out});
`else
        got_m.push_back({56'b0, mask_out});
`endif
        $display("[TB] mask pulse mask_out=%02h", mask_out);
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit l);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    $display("[TB] sent data=%08h last=%0b", d, l);
  endtask

  task automatic verify(input string name);
    check({name, "_stream_len"}, 64'(got_s.size()), 64'(exp_s.size()));
    for (int i = 0; i < exp_s.size() && i < got_s.size(); i++)
      check($sformatf("%s_entry%0d", name, i), got_s[i], exp_s[i]);
    check({name, "_mask_pulses"}, 64'(got_m.size()), 64'(exp_m.size()));
    for (int i = 0; i < exp_m.size() && i < got_m.size(); i++)
      check($sformatf("%s_mask%0d", name, i), got_m[i], exp_m[i]);
    got_s.delete(); exp_s.delete(); got_m.delete(); exp_m.delete();
  endtask

  task automatic drain();
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    #2;
    check("rst_in_ready",   64'(in_ready),   64'd0);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_index",  64'(out_index),  64'd0);
    check("rst_out_data",   64'(out_data),   64'd0);
    check("rst_out_last",   64'(out_last),   64'd0);
    check("rst_mask_valid", 64'(mask_valid), 64'd0);
    check("rst_mask_out",   64'(mask_out),   64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Sparse vector with nonzeros at 1, 4, 7.
    send(32'h0, 0); send(32'h40400000, 0); send(32'h0, 0); send(32'h0, 0);
    send(32'hC0000000, 0); send(32'h0, 0); send(32'h0, 0); send(32'h3FC00000, 1);
    exp_s.push_back(ent(1, 32'h40400000, 0));
    exp_s.push_back(ent(4, 32'hC0000000, 0));
    exp_s.push_back(ent(7, 32'h3FC00000, 1));
    exp_m.push_back(mk(8'h92, 3));
    drain();
    verify("sparse");

    // All-zero vector including -0.0.
    send(32'h80000000, 0); send(32'h0, 0); send(32'h80000000, 0); send(32'h80000000, 1);
    exp_m.push_back(mk(8'h00, 0));
    drain();
    verify("allzero");

    // Back-to-back vectors; first ends on a nonzero with hold full (denormal included).
    send(32'h3F800000, 0); send(32'h00000001, 0); send(32'h40800000, 1);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    send(32'h40000000, 0); send(32'h0, 1);
    exp_s.push_back(ent(0, 32'h3F800000, 0));
    exp_s.push_back(ent(1, 32'h00000001, 0));
    exp_s.push_back(ent(2, 32'h40800000, 1));
    exp_s.push_back(ent(0, 32'h40000000, 1));
    exp_m.push_back(mk(8'h07, 3));
    exp_m.push_back(mk(8'h01, 1));
    drain();
    verify("b2b");

    // Dense vector with output stalled for 10 cycles.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'h41000000 + 32'(i), i == 7);
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        check("stall_in_ready",  64'(in_ready),  64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_head_idx",  64'(out_index), 64'd0);
        check("stall_head_data", 64'(out_data),  64'h41000000);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 8; i++) exp_s.push_back(ent(i, 32'h41000000 + 32'(i), i == 7));
    exp_m.push_back(mk(8'hFF, 8));
    drain();
    verify("stall");

    // Ten words without in_last: forced end at index 7, then restart at 0.
    send(32'h3F800000, 0);
    for (int i = 1; i < 7; i++) send(32'h0, 0);
    send(32'h40000000, 0); send(32'h40400000, 0); send(32'h0, 0);
    send(32'h0, 1);
    exp_s.push_back(ent(0, 32'h3F800000, 0));
    exp_s.push_back(ent(7, 32'h40000000, 1));
    exp_s.push_back(ent(0, 32'h40400000, 1));
    exp_m.push_back(mk(8'h81, 2));
    exp_m.push_back(mk(8'h01, 1));
    drain();
    verify("forced");

    // Reset mid-vector with two entries queued.
    out_ready = 1'b0;
    send(32'h3F800000, 0); send(32'h40000000, 0); send(32'h40400000, 0);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_mask_out",  64'(mask_out),  64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(32'h3F800000, 1);
    exp_s.push_back(ent(0, 32'h3F800000, 1));
    exp_m.push_back(mk(8'h01, 1));
    drain();
    verify("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_stream_encoder.md
Name: sparse_stream_encoder

Overview:
- Producer end of the sparse PE index/data protocol.
- Takes dense fp32 vectors one word per cycle and emits only nonzero elements as (index, data) pairs, with end-of-vector tagging.
- Also emits the per-vector nonzero bitmap in the form the PE's mask_conf/new_mask load expects.
- Sits at the array edge, feeding the data_i_up / data_i_le columns and rows.

Parameters:
- Data_Width, 32, element width (IEEE fp32).
- Vec_Len, 32, maximum elements per vector; equals the PE Mask_Width.
- Index_Width, $clog2(Vec_Len), element index width.
- Fifo_Depth, 4, output FIFO entries (power of two).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  dense word valid.
- in_ready  out  1  encoder accepts a word this cycle.
- in_data  in  Data_Width  dense element.
- in_last  in  1  final element of the current vector.
- out_valid  out  1  sparse entry available.
- out_ready  in  1  downstream takes the entry.
- out_index  out  Index_Width  element position in its vector.
- out_data  out  Data_Width  nonzero element value.
- out_last  out  1  last nonzero entry of its vector.
- mask_valid  out  1  one-cycle pulse; mask_out is valid.
- mask_out  out  Vec_Len  bit i set when element i was nonzero.

Behaviour:
- Reset (async, rst=1): state RUN, element counter 0, hold register empty, FIFO empty, mask accumulator 0. Outputs: in_ready 0 while rst is high, out_valid 0, out_last 0, out_index 0, out_data 0, mask_valid 0, mask_out 0.
- Zero test: a word is zero when in_data[30:0]==0. -0.0 counts as zero. Denormals are nonzero.
- Accept: a word is accepted when in_valid && in_ready, and gets index = element counter.
  - The counter increments per accepted word.
  - The counter returns to 0 after in_last, or after index Vec_Len-1. The latter is a forced vector end, treated exactly as if in_last were set.
- Hold register: stores the most recent nonzero of the current vector so the last nonzero can be tagged.
  - Nonzero accepted while hold is full: push hold with last=0; new word goes into hold.
  - Nonzero accepted while hold is empty: word goes into hold.
  - Zero word: nothing is pushed; the mask bit stays 0.
- Vector end:
  - Nonzero final word with hold full: push hold (last=0); final word goes into hold marked last; go to FLUSH.
  - Nonzero final word with hold empty: push the final word with last=1.
  - Zero final word with hold full: push hold with last=1.
  - Zero final word with hold empty: push nothing (all-zero vector produces no stream entries).
- FLUSH: in_ready=0. The following cycle pushes the hold entry with last=1 (waits while the FIFO is full), then returns to RUN.
- Mask: the accumulator sets bit[index] per nonzero. In the cycle after a vector end is accepted, mask_valid=1 and mask_out holds the full bitmap; the accumulator clears for the next vector. mask_out keeps its value until the next pulse.
- in_ready = (state==RUN) && !rst && fifo_count<Fifo_Depth. This is conservative: a same-cycle pop does not raise ready.
- FIFO behaviour:
  - Push and pop in the same cycle are legal at any count.
  - out_valid = count!=0.
  - out_index, out_data and out_last come from the head entry and are stable while out_valid && !out_ready.
- Latency: a nonzero accepted at cycle t with an empty FIFO appears at the output at t+1 at the earliest, once released from hold.
- Reset mid-vector: partial vector, FIFO contents and mask are discarded; no mask_valid pulse.

Optional Feature:
- Macro SPARSE_ENC_NNZ_COUNT_EN.
- When defined: extra output port nnz_count (Index_Width+1 bits), valid with mask_valid, holding the nonzero count of that vector (0..Vec_Len). Reset value 0.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package: fp32 field constants (sign bit 31, magnitude [30:0]), the is_zero_fp32 function, and the default Vec_Len/Index_Width so the encoder and the PE agree on mask width.
- One sub-module, sparse_enc_fifo: synchronous FIFO with count, full/empty, and simultaneous push/pop, parameterised by entry width (Index_Width+Data_Width+1) and depth.

Test Plan:
- Vec_Len=8, input {0,3.0,0,0,-2.0,0,0,1.5}, last on element 7, out_ready=1 -> stream (1,0x40400000,0),(4,0xC0000000,0),(7,0x3FC00000,1); mask_out=0x92 pulsed once.
- All-zero vector with -0.0 (0x80000000) entries and last -> no out_valid; mask_valid pulse with mask_out=0; NNZ variant nnz_count=0.
- Back-to-back vectors, final word nonzero with hold full -> FLUSH cycle with in_ready=0; out_last on the correct entry; second vector indices restart at 0.
- out_ready=0 for 10 cycles during a dense all-nonzero vector -> in_ready falls once 4 entries are queued; no loss or duplication; head entry stable.
- Vec_Len+2 words without in_last -> forced end at index Vec_Len-1 with out_last; next word gets index 0.
- Assert rst mid-vector with 2 entries queued -> out_valid=0 and mask_out=0 immediately; no mask_valid; next vector encodes cleanly.
